// File: rtl/alu_sequencer_pkg.sv
// Shared calculator definitions: key/opcode codes, sequencer states, sizing defaults.
package calc_pkg;

    localparam int unsigned DIGITS  = 4;
    localparam int unsigned BIN_W   = 14;
    localparam int unsigned MAX_VAL = 9999;
    localparam int unsigned BCD_W   = 4 * DIGITS;
    localparam int unsigned CNT_W   = $clog2(BIN_W + 1);

    localparam logic [3:0] EQUAL = 4'd10;
    localparam logic [3:0] AC    = 4'd11;
    localparam logic [3:0] PLUS  = 4'd12;
    localparam logic [3:0] MINUS = 4'd13;
    localparam logic [3:0] MULT  = 4'd14;
    localparam logic [3:0] DIV   = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IN_CONV,
        S_EXEC,
        S_OUT_CONV,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/result bundle between the keypad FSM (master) and the ALU sequencer (slave).
interface alu_sequencer_if;
    import calc_pkg::*;

    logic             start;
    logic [3:0]       op;
    logic [BCD_W-1:0] num1_bcd;
    logic [BCD_W-1:0] num2_bcd;
    logic             busy;
    logic             done;
    logic [BCD_W-1:0] result_bcd;
    logic             neg;
    logic             err;

    modport master (
        output start, op, num1_bcd, num2_bcd,
        input  busy, done, result_bcd, neg, err
    );

    modport slave (
        input  start, op, num1_bcd, num2_bcd,
        output busy, done, result_bcd, neg, err
    );

endinterface

// File: rtl/alu_sequencer_bin2bcd_dd.sv
// Iterative double-dabble binary-to-BCD converter; one bit per clock, load edge included.
module bin2bcd_dd #(
    parameter int unsigned BIN_W  = calc_pkg::BIN_W,
    parameter int unsigned DIGITS = calc_pkg::DIGITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    logic [BIN_W-1:0] bin_q;
    logic [CNT_W-1:0] cnt_q;

    // Add 3 to every digit >= 5, then shift left pulling in the next binary bit.
    function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] v, input logic bit_in);
        logic [BCD_W-1:0] a;
        a = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (a[4*i +: 4] >= 4'd5) begin
                a[4*i +: 4] = a[4*i +: 4] + 4'd3;
            end
        end
        return {a[BCD_W-2:0], bit_in};
    endfunction

    // Load performs the first shift (adjusting an all-zero BCD is a no-op); BIN_W-1 steps follow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_q <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bcd   <= '0;
        end else begin
            done <= 1'b0;
            if (load) begin
                bcd   <= {(BCD_W-1)'(0), bin[BIN_W-1]};
                bin_q <= {bin[BIN_W-2:0], 1'b0};
                cnt_q <= CNT_W'(BIN_W - 1);
                busy  <= 1'b1;
            end else if (busy) begin
                bcd   <= dd_step(bcd, bin_q[BIN_W-1]);
                bin_q <= {bin_q[BIN_W-2:0], 1'b0};
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle BCD calculator engine: BCD->binary, add/sub/mul/div, binary->BCD.
module alu_sequencer
    import calc_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    alu_sequencer_if.slave bus
);

    localparam logic [BIN_W:0]     MAX_SUM  = (BIN_W + 1)'(MAX_VAL);
    localparam logic [2*BIN_W-1:0] MAX_PROD = (2 * BIN_W)'(MAX_VAL);

    seq_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [3:0]         op_q;
    logic [BCD_W-1:0]   n1_q, n2_q;
    logic [BIN_W-1:0]   acc1_q, acc2_q;
    logic               bad_q;
    logic               neg_pend_q;
    logic [2*BIN_W-1:0] prod_q;

    logic [3:0]         digit1, digit2;
    logic [BIN_W-1:0]   acc1_d, acc2_d;
    logic               digit_bad;
    logic [BIN_W:0]     add_sum;
    logic               a_ge_b;
    logic [BIN_W-1:0]   diff;
    logic [BIN_W:0]     mul_sum;
    logic [2*BIN_W-1:0] mul_next;
    logic [BIN_W:0]     div_shift;
    logic               div_ge;
    logic [BIN_W-1:0]   div_trial;
    logic [2*BIN_W-1:0] div_next;

    logic               accept_c;
    logic               fail_c;
    logic               conv_load_c;
    logic [BIN_W-1:0]   conv_val_c;
    logic               conv_busy;
    logic               conv_done;
    logic [BCD_W-1:0]   conv_bcd;

    // Operand digit conversion, MS digit first.
    assign digit1    = n1_q[BCD_W-1 -: 4];
    assign digit2    = n2_q[BCD_W-1 -: 4];
    assign acc1_d    = acc1_q * BIN_W'(10) + BIN_W'(digit1);
    assign acc2_d    = acc2_q * BIN_W'(10) + BIN_W'(digit2);
    assign digit_bad = (digit1 > 4'd9) || (digit2 > 4'd9);

    // Single-cycle add/sub; subtraction yields a magnitude plus sign.
    assign add_sum = {1'b0, acc1_q} + {1'b0, acc2_q};
    assign a_ge_b  = acc1_q >= acc2_q;
    assign diff    = a_ge_b ? (acc1_q - acc2_q) : (acc2_q - acc1_q);

    // Shift-add multiply: {partial, multiplier} shifts right, multiplicand added on LSB.
    assign mul_sum  = {1'b0, prod_q[2*BIN_W-1:BIN_W]} + (prod_q[0] ? {1'b0, acc1_q} : '0);
    assign mul_next = {mul_sum, prod_q[BIN_W-1:1]};

    // Restoring divide: {remainder, dividend/quotient} shifts left one bit per step.
    assign div_shift = prod_q[2*BIN_W-1:BIN_W-1];
    assign div_ge    = div_shift >= {1'b0, acc2_q};
    assign div_trial = div_shift[BIN_W-1:0] - acc2_q;
    assign div_next  = div_ge ? {div_trial, prod_q[BIN_W-2:0], 1'b1}
                              : {div_shift[BIN_W-1:0], prod_q[BIN_W-2:0], 1'b0};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; error exits bypass output conversion.
    always_comb begin
        state_d     = state_q;
        accept_c    = 1'b0;
        fail_c      = 1'b0;
        conv_load_c = 1'b0;
        conv_val_c  = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && (bus.op >= PLUS)) begin
                    accept_c = 1'b1;
                    state_d  = S_IN_CONV;
                end
            end
            S_IN_CONV: begin
                if (cnt_q == '0) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (bad_q || ((op_q == DIV) && (acc2_q == '0))) begin
                    fail_c = 1'b1;
                end else begin
                    case (op_q)
                        PLUS: begin
                            if (add_sum > MAX_SUM) begin
                                fail_c = 1'b1;
                            end else begin
                                conv_load_c = 1'b1;
                                conv_val_c  = add_sum[BIN_W-1:0];
                            end
                        end
                        MINUS: begin
                            conv_load_c = 1'b1;
                            conv_val_c  = diff;
                        end
                        MULT: begin
                            if (cnt_q == '0) begin
                                if (mul_next > MAX_PROD) begin
                                    fail_c = 1'b1;
                                end else begin
                                    conv_load_c = 1'b1;
                                    conv_val_c  = mul_next[BIN_W-1:0];
                                end
                            end
                        end
                        default: begin
                            if (cnt_q == '0) begin
                                conv_load_c = 1'b1;
                                conv_val_c  = div_next[BIN_W-1:0];
                            end
                        end
                    endcase
                end
                if (fail_c) begin
                    state_d = S_DONE;
                end else if (conv_load_c) begin
                    state_d = S_OUT_CONV;
                end
            end
            S_OUT_CONV: begin
                if (conv_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q          <= '0;
            op_q           <= '0;
            n1_q           <= '0;
            n2_q           <= '0;
            acc1_q         <= '0;
            acc2_q         <= '0;
            bad_q          <= 1'b0;
            neg_pend_q     <= 1'b0;
            prod_q         <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.result_bcd <= '0;
            bus.neg        <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            bus.busy <= (state_d != S_IDLE) || conv_busy;
            bus.done <= (state_d == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        op_q           <= bus.op;
                        n1_q           <= bus.num1_bcd;
                        n2_q           <= bus.num2_bcd;
                        acc1_q         <= '0;
                        acc2_q         <= '0;
                        bad_q          <= 1'b0;
                        neg_pend_q     <= 1'b0;
                        cnt_q          <= CNT_W'(DIGITS - 1);
                        bus.result_bcd <= '0;
                        bus.neg        <= 1'b0;
                        bus.err        <= 1'b0;
                    end
                end
                S_IN_CONV: begin
                    acc1_q <= acc1_d;
                    acc2_q <= acc2_d;
                    n1_q   <= {n1_q[BCD_W-5:0], 4'h0};
                    n2_q   <= {n2_q[BCD_W-5:0], 4'h0};
                    bad_q  <= bad_q | digit_bad;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        cnt_q  <= CNT_W'(BIN_W - 1);
                        prod_q <= (op_q == MULT) ? {BIN_W'(0), acc2_d} : {BIN_W'(0), acc1_d};
                    end
                end
                S_EXEC: begin
                    cnt_q      <= cnt_q - 1'b1;
                    prod_q     <= (op_q == MULT) ? mul_next : div_next;
                    neg_pend_q <= (op_q == MINUS) && !a_ge_b;
                    if (fail_c) begin
                        bus.err <= 1'b1;
                    end
                end
                S_OUT_CONV: begin
                    if (conv_done) begin
                        bus.result_bcd <= conv_bcd;
                        bus.neg        <= neg_pend_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    bin2bcd_dd #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .load  (conv_load_c),
        .bin   (conv_val_c),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: arithmetic results, latency, error exits, start/reset corner cases.
module tb_alu_sequencer;
    import calc_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   seen   = 0;

    alu_sequencer_if bus();

    alu_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; cyc counts cycles since the start-capture cycle N.
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    // Present start in cycle N; returns at the sample point of cycle N+1.
    task automatic launch(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = o;
        bus.num1_bcd = a;
        bus.num2_bcd = b;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_done(input int limit);
        while (bus.done !== 1'b1 && cyc < limit) step();
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [15:0] a,
                          input logic [15:0] b, input int lat, input logic [15:0] res,
                          input logic n, input logic e);
        launch(o, a, b);
        check({tag, " busy"}, 32'(bus.busy), 32'd1);
        check({tag, " cleared"}, 32'({bus.result_bcd, bus.neg, bus.err}), 32'd0);
        wait_done(60);
        check({tag, " latency"}, 32'(cyc), 32'(lat));
        check({tag, " result"}, 32'(bus.result_bcd), 32'(res));
        check({tag, " neg"}, 32'(bus.neg), 32'(n));
        check({tag, " err"}, 32'(bus.err), 32'(e));
        step();
        check({tag, " done width"}, 32'(bus.done), 32'd0);
        check({tag, " hold"}, 32'(bus.result_bcd), 32'(res));
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.op       = 4'd0;
        bus.num1_bcd = 16'h0;
        bus.num2_bcd = 16'h0;

        repeat (2) @(negedge clk);
        check("reset outputs", 32'({bus.busy, bus.done, bus.neg, bus.err, bus.result_bcd}), 32'd0);
        reset = 1'b0;

        run_op("add", PLUS, 16'h1234, 16'h0567, 20, 16'h1801, 1'b0, 1'b0);

        // Non-arithmetic opcode must be ignored and leave the last result alone.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = EQUAL;
        @(negedge clk);
        bus.start = 1'b0;
        seen = 0;
        repeat (6) begin
            if (bus.busy || bus.done) seen++;
            @(negedge clk);
        end
        check("equal ignored", 32'(seen), 32'd0);
        check("equal hold", 32'(bus.result_bcd), 32'h1801);

        run_op("sub neg", MINUS, 16'h0005, 16'h0009, 20, 16'h0004, 1'b1, 1'b0);
        run_op("sub pos", MINUS, 16'h0009, 16'h0005, 20, 16'h0004, 1'b0, 1'b0);
        run_op("mul", MULT, 16'h0123, 16'h0081, 33, 16'h9963, 1'b0, 1'b0);
        run_op("mul ovf", MULT, 16'h0100, 16'h0100, 19, 16'h0000, 1'b0, 1'b1);
        run_op("div", DIV, 16'h0007, 16'h0002, 33, 16'h0003, 1'b0, 1'b0);
        run_op("div zero", DIV, 16'h9999, 16'h0000, 6, 16'h0000, 1'b0, 1'b1);
        run_op("bad digit", DIV, 16'h12A4, 16'h0002, 6, 16'h0000, 1'b0, 1'b1);
        run_op("add ovf", PLUS, 16'h9999, 16'h0001, 6, 16'h0000, 1'b0, 1'b1);
        run_op("add max", PLUS, 16'h9998, 16'h0001, 20, 16'h9999, 1'b0, 1'b0);

        // A second start while busy must not disturb the running multiply.
        launch(MULT, 16'h0123, 16'h0081);
        while (cyc < 10) step();
        bus.start    = 1'b1;
        bus.op       = PLUS;
        bus.num1_bcd = 16'h0002;
        bus.num2_bcd = 16'h0002;
        step();
        bus.start = 1'b0;
        wait_done(60);
        check("busy start latency", 32'(cyc), 32'd33);
        check("busy start result", 32'(bus.result_bcd), 32'h9963);
        check("busy start err", 32'(bus.err), 32'd0);

        // Asynchronous reset mid-multiply aborts with no done pulse.
        launch(MULT, 16'h0100, 16'h0099);
        while (cyc < 15) step();
        reset = 1'b1;
        #1;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort outputs", 32'({bus.done, bus.neg, bus.err, bus.result_bcd}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        check("abort no done", 32'(seen), 32'd0);

        run_op("after reset", PLUS, 16'h0002, 16'h0003, 20, 16'h0005, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
